// File: rtl/nand_quad_tester_ctrl.sv
// Functional-test sequencer for a quad 2-input NAND package.
// Broadcasts the four (A,B) vectors 00,01,10,11 to every gate. Each vector
// is held for SETTLE_CYCLES cycles, then every Y bit is compared against
// ~(A&B). The result is reported as a per-gate fail mask and a PASS flag.
module nand_quad_tester_ctrl #(
  parameter int NGATE         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic [NGATE-1:0] Y,
  output logic [NGATE-1:0] A,
  output logic [NGATE-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [NGATE-1:0] FAIL_MASK
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_RELOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_REPORT
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [CW-1:0]    settle_cnt_q, settle_cnt_d;
  logic [NGATE-1:0] mask_q, mask_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;

  // State and datapath registers; reset takes effect immediately, mid-run included.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      settle_cnt_q <= '0;
      mask_q       <= '0;
      pass_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      settle_cnt_q <= settle_cnt_d;
      mask_q       <= mask_d;
      pass_q       <= pass_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic and the A/B/DONE outputs that follow the current state.
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    settle_cnt_d = settle_cnt_q;
    mask_d       = mask_q;
    pass_d       = pass_q;
    busy_d       = busy_q;
    A            = '0;
    B            = '0;
    DONE         = 1'b0;

    case (state_q)
      S_IDLE: begin
        // ABORT in IDLE blocks a simultaneous START.
        if (START && !ABORT) begin
          vec_d        = 2'd0;
          mask_d       = '0;
          pass_d       = 1'b0;
          settle_cnt_d = SETTLE_RELOAD;
          busy_d       = 1'b1;
          state_d      = S_SETTLE;
        end
      end

      S_SETTLE: begin
        A = {NGATE{vec_q[1]}};
        B = {NGATE{vec_q[0]}};
        if (ABORT) begin
          state_d      = S_IDLE;
          vec_d        = 2'd0;
          settle_cnt_d = '0;
          mask_d       = '0;
          pass_d       = 1'b0;
          busy_d       = 1'b0;
        end else if (settle_cnt_q == '0) begin
          state_d = S_CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q - CW'(1);
        end
      end

      S_CHECK: begin
        A = {NGATE{vec_q[1]}};
        B = {NGATE{vec_q[0]}};
        if (ABORT) begin
          state_d      = S_IDLE;
          vec_d        = 2'd0;
          settle_cnt_d = '0;
          mask_d       = '0;
          pass_d       = 1'b0;
          busy_d       = 1'b0;
        end else begin
          mask_d = mask_q | (Y ^ {NGATE{~(vec_q[1] & vec_q[0])}});
          if (vec_q == 2'd3) begin
            // PASS is settled here so it is already valid alongside DONE.
            pass_d  = ~|mask_d;
            state_d = S_REPORT;
          end else begin
            vec_d        = vec_q + 2'd1;
            settle_cnt_d = SETTLE_RELOAD;
            state_d      = S_SETTLE;
          end
        end
      end

      S_REPORT: begin
        // ABORT is deliberately ignored so the report always completes.
        DONE    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign BUSY      = busy_q;
  assign PASS      = pass_q;
  assign FAIL_MASK = mask_q;

endmodule

// File: tb/tb_nand_quad_tester_ctrl.sv
// Directed bench for nand_quad_tester_ctrl with a behavioural NAND package
// model whose gates can be made stuck-at-0, stuck-at-1, or wrong on vector 11.
module tb_nand_quad_tester_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       START;
  logic       ABORT;
  logic [3:0] Y;
  logic [3:0] A;
  logic [3:0] B;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [3:0] FAIL_MASK;

  logic [3:0] sa0;
  logic [3:0] sa1;
  logic [3:0] flip11;

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  always #5 CLK = ~CLK;

  nand_quad_tester_ctrl #(.NGATE(4), .SETTLE_CYCLES(2)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .ABORT     (ABORT),
    .Y         (Y),
    .A         (A),
    .B         (B),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .PASS      (PASS),
    .FAIL_MASK (FAIL_MASK)
  );

  // Package model: ideal NAND, then stuck-at faults, then a gate that reads wrong only on A=B=1.
  always_comb begin
    Y = ((~(A & B)) & ~sa0) | sa1;
    Y = Y ^ (flip11 & {4{A[0] & B[0]}});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge and bump the cycle number.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Full run with START for one cycle; checks timing, vector order and final result.
  task automatic full_run(input logic [3:0] exp_mask);
    @(posedge CLK);
    #1;
    cyc   = 0;
    START = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      START = 1'b0;
      chk("done_timing", DONE, (cyc == 13));
      chk("busy_window", BUSY, (cyc <= 13));
      if ((cyc % 3 == 0) && (cyc <= 12)) begin
        logic [1:0] v;
        v = 2'(cyc / 3 - 1);
        chk("vec_A", A, {4{v[1]}});
        chk("vec_B", B, {4{v[0]}});
      end
      if (cyc == 13) begin
        chk("mask_at_done", FAIL_MASK, exp_mask);
        chk("pass_at_done", PASS, (exp_mask == 4'b0000));
      end
      if (cyc == 16) begin
        chk("mask_hold", FAIL_MASK, exp_mask);
        chk("pass_hold", PASS, (exp_mask == 4'b0000));
        chk("idle_A", A, 4'b0000);
      end
    end
  endtask

  initial begin
    cyc    = 0;
    RST_N  = 1'b0;
    START  = 1'b0;
    ABORT  = 1'b0;
    sa0    = 4'b0000;
    sa1    = 4'b0000;
    flip11 = 4'b0000;

    // Reset values with no clock edge seen yet.
    #2;
    chk("rst_A", A, 4'b0000);
    chk("rst_B", B, 4'b0000);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_pass", PASS, 1'b0);
    chk("rst_mask", FAIL_MASK, 4'b0000);
    @(negedge CLK);
    RST_N = 1'b1;

    // Good part.
    full_run(4'b0000);

    // Gate 2 stuck-at-1 (fails on 11), gate 0 stuck-at-0 (fails on 00,01,10).
    sa1 = 4'b0100;
    sa0 = 4'b0001;
    full_run(4'b0101);
    sa1 = 4'b0000;
    sa0 = 4'b0000;

    // Gate 3 reads high on vector 11 only: proves the last vector is checked.
    flip11 = 4'b1000;
    full_run(4'b1000);
    flip11 = 4'b0000;

    // START pulsed again at cycle 5 while busy: one run, DONE only at cycle 13.
    @(posedge CLK);
    #1;
    cyc   = 0;
    START = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      START = (cyc == 5);
      chk("restart_done", DONE, (cyc == 13));
      chk("restart_busy", BUSY, (cyc <= 13));
    end
    START = 1'b0;

    // ABORT at cycle 6 with gate 0 stuck-at-0 so the mask is already non-zero.
    sa0 = 4'b0001;
    @(posedge CLK);
    #1;
    cyc   = 0;
    START = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      START = 1'b0;
      ABORT = (cyc == 6);
      chk("abort_no_done", DONE, 1'b0);
      if (cyc == 4) chk("abort_premask", FAIL_MASK, 4'b0001);
      if (cyc == 6) chk("abort_busy_before", BUSY, 1'b1);
      if (cyc == 7) begin
        chk("abort_busy", BUSY, 1'b0);
        chk("abort_A", A, 4'b0000);
        chk("abort_B", B, 4'b0000);
        chk("abort_mask", FAIL_MASK, 4'b0000);
        chk("abort_pass", PASS, 1'b0);
      end
    end
    ABORT = 1'b0;

    // Asynchronous reset at cycle 8 of a run, then a clean run afterwards.
    @(posedge CLK);
    #1;
    cyc   = 0;
    START = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      START = 1'b0;
    end
    chk("prereset_busy", BUSY, 1'b1);
    chk("prereset_mask", FAIL_MASK, 4'b0001);
    RST_N = 1'b0;
    #1;
    chk("arst_A", A, 4'b0000);
    chk("arst_B", B, 4'b0000);
    chk("arst_busy", BUSY, 1'b0);
    chk("arst_done", DONE, 1'b0);
    chk("arst_pass", PASS, 1'b0);
    chk("arst_mask", FAIL_MASK, 4'b0000);
    sa0 = 4'b0000;
    @(negedge CLK);
    RST_N = 1'b1;
    full_run(4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
